alu_seq: RTL and testbench

Parametrised sequential ALU, the next generation of the SAP-1 8-bit add/subtract unit. It accepts operations over a start/busy/done handshake, registers the result together with status flags, and drives the registered result onto the shared bus through a tri-state output gated by `enable`. Single-cycle logic and arithmetic ops are supported, plus an optional multi-cycle shift-add multiplier. It sits between the A/B registers and the W bus, and feeds flags to the controller for conditional jumps.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_adder.sv | 28 ++
 rtl/alu_seq.sv | 174 +++++++++++++++++
 tb/tb_alu_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the status-flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_adder.sv
// Ripple-carry adder shared by ADD, SUB and the multiply accumulate step.
module alu_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             cprev
);

  logic [WIDTH:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[WIDTH];
  assign cprev = c[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with start/busy/done handshake and tri-stated result bus.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier for op 111.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             enable,
  output wire  [WIDTH-1:0] result_output,
  output logic             busy,
  output logic             done,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

`ifdef ALU_MUL_EN
  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
`else
  localparam int AW = WIDTH;
`endif

  alu_op_e          opc;
  logic [AW-1:0]    add_a, add_b, add_s;
  logic             add_ci, add_co, add_cp;
  logic [WIDTH-1:0] res_d, result_q;
  alu_flags_t       flg_d, flags_q;
  logic             idle;

  assign opc = alu_op_e'(op);

`ifdef ALU_MUL_EN
  alu_state_e       state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc, mcand, acc_nx;
  logic [WIDTH-1:0] mplier;

  assign idle   = (state == IDLE);
  assign busy   = (state == MUL);
  assign acc_nx = mplier[0] ? add_s : acc;
`else
  assign idle = 1'b1;
  assign busy = 1'b0;
`endif

  // ADD/SUB ride in the top WIDTH bits of the wide adder so cout/cprev land on
  // the W-bit boundary; the all-ones low half turns SUB's cin into the +1.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
`ifdef ALU_MUL_EN
    if (!idle) begin
      add_a = acc;
      add_b = mcand;
    end else begin
      add_a  = {operand1, {WIDTH{1'b0}}};
      add_b  = (opc == OP_SUB) ? {~operand2, {WIDTH{1'b1}}} : {operand2, {WIDTH{1'b0}}};
      add_ci = (opc == OP_SUB);
    end
`else
    add_a  = operand1;
    add_b  = (opc == OP_SUB) ? ~operand2 : operand2;
    add_ci = (opc == OP_SUB);
`endif
  end

  alu_adder #(.WIDTH(AW)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_ci),
    .sum  (add_s),
    .cout (add_co),
    .cprev(add_cp)
  );

  // Single-cycle result; op 111 falls to the zero default when not handled here.
  always_comb begin
    res_d = '0;
    flg_d = '0;
    case (opc)
      OP_ADD, OP_SUB: begin
        res_d   = add_s[AW-1 -: WIDTH];
        flg_d.c = add_co;
        flg_d.v = add_co ^ add_cp;
      end
      OP_AND: res_d = operand1 & operand2;
      OP_OR:  res_d = operand1 | operand2;
      OP_XOR: res_d = operand1 ^ operand2;
      OP_SHL: begin
        res_d   = {operand1[WIDTH-2:0], 1'b0};
        flg_d.c = operand1[WIDTH-1];
      end
      OP_SHR: begin
        res_d   = {1'b0, operand1[WIDTH-1:1]};
        flg_d.c = operand1[0];
      end
      default: res_d = '0;
    endcase
    flg_d.z = (res_d == '0);
    flg_d.n = res_d[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      done     <= 1'b0;
`ifdef ALU_MUL_EN
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef ALU_MUL_EN
      case (state)
        IDLE: if (start) begin
          if (opc == OP_MUL) begin
            state  <= MUL;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, operand1};
            mplier <= operand2;
            cnt    <= CW'(WIDTH);
          end else begin
            result_q <= res_d;
            flags_q  <= flg_d;
            done     <= 1'b1;
          end
        end
        MUL: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state    <= IDLE;
            result_q <= acc_nx[WIDTH-1:0];
            flags_q  <= '{c: |acc_nx[AW-1:WIDTH],
                          z: (acc_nx[WIDTH-1:0] == '0),
                          n: acc_nx[WIDTH-1],
                          v: 1'b0};
            done     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
`else
      if (start) begin
        result_q <= res_d;
        flags_q  <= flg_d;
        done     <= 1'b1;
      end
`endif
    end
  end

  assign result_output = enable ? result_q : {WIDTH{1'bz}};
  assign flag_c = flags_q.c;
  assign flag_z = flags_q.z;
  assign flag_n = flags_q.n;
  assign flag_v = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table for single-cycle ops plus hand sequences for MUL/reset.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] operand1 = 8'h00;
  logic [7:0] operand2 = 8'h00;
  logic       enable = 1'b1;
  wire  [7:0] result_output;
  logic       busy, done, flag_c, flag_z, flag_n, flag_v;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .operand1     (operand1),
    .operand2     (operand2),
    .enable       (enable),
    .result_output(result_output),
    .busy         (busy),
    .done         (done),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .flag_v       (flag_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] cznv;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; op = o; operand1 = a; operand2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [3:0] flags();
    return {flag_c, flag_z, flag_n, flag_v};
  endfunction

  // Counts busy samples until done, bounded; returns with done sampled.
  task automatic wait_done(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int nb;
    int seen;
    //            op      a      b      res    C Z N V
    vt[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b0011};
    vt[1]  = '{3'b001, 8'h05, 8'h05, 8'h00, 4'b1100};
    vt[2]  = '{3'b001, 8'h03, 8'h05, 8'hFE, 4'b0010};
    vt[3]  = '{3'b101, 8'h81, 8'h00, 8'h02, 4'b1000};
    vt[4]  = '{3'b110, 8'h01, 8'h00, 8'h00, 4'b1100};
    vt[5]  = '{3'b010, 8'hF0, 8'h0F, 8'h00, 4'b0100};
    vt[6]  = '{3'b011, 8'hF0, 8'h0F, 8'hFF, 4'b0010};
    vt[7]  = '{3'b100, 8'hAA, 8'hFF, 8'h55, 4'b0000};
    vt[8]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b1100};
    vt[9]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b1001};
    vt[10] = '{3'b000, 8'h80, 8'h80, 8'h00, 4'b1101};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result_output, 8'h00);
    chk("rst_flags", flags(), 4'b0000);
    chk("rst_busy_done", {busy, done}, 2'b00);
    @(negedge clk) rst = 1'b0;

    // Back-to-back issue: each start lands in the cycle the previous done is high.
    for (int i = 0; i < 11; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      chk($sformatf("vec%0d_done", i), done, 1'b1);
      chk($sformatf("vec%0d_result", i), result_output, vt[i].res);
      chk($sformatf("vec%0d_flags", i), flags(), vt[i].cznv);
    end
    @(posedge clk); #1;
    chk("done_drops", done, 1'b0);
    chk("hold_result", result_output, 8'h00);

    issue(3'b000, 8'h7F, 8'h01);
    enable = 1'b0; #1;
    chk("tristate_not_driven", (result_output !== 8'h80), 1'b1);
    enable = 1'b1; #1;
    chk("enable_drives", result_output, 8'h80);

`ifdef ALU_MUL_EN
    issue(3'b111, 8'h0F, 8'h11);
    wait_done(nb);
    chk("mul1_busy_cycles", nb, 8);
    chk("mul1_done", {done, busy}, 2'b10);
    chk("mul1_result", result_output, 8'hFF);
    chk("mul1_flags", flags(), 4'b0010);

    issue(3'b111, 8'h10, 8'h10);
    wait_done(nb);
    chk("mul2_done", done, 1'b1);
    chk("mul2_result", result_output, 8'h00);
    chk("mul2_flags", flags(), 4'b1100);

    // ADD started mid-MUL must be dropped, not queued.
    issue(3'b111, 8'h03, 8'h05);
    repeat (2) begin @(posedge clk); #1; end
    issue(3'b000, 8'h01, 8'h01);
    chk("ign_busy", {busy, done}, 2'b10);
    chk("ign_hold", result_output, 8'h00);
    wait_done(nb);
    chk("ign_done", done, 1'b1);
    chk("ign_result", result_output, 8'h0F);
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (done) seen++; end
    chk("ign_no_queue", seen, 0);
    chk("ign_result_hold", result_output, 8'h0F);

    issue(3'b111, 8'hFF, 8'hFF);
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_busy_pre", busy, 1'b1);
`else
    issue(3'b111, 8'h03, 8'h04);
    chk("mul_off_done", {done, busy}, 2'b10);
    chk("mul_off_result", result_output, 8'h00);
    chk("mul_off_flags", flags(), 4'b0100);
    issue(3'b011, 8'h00, 8'h0F);
    chk("pre_rst_result", result_output, 8'h0F);
`endif

    @(negedge clk) rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result_output, 8'h00);
    chk("abort_flags", flags(), 4'b0000);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (done || busy) seen++; end
    chk("abort_no_done", seen, 0);

    issue(3'b000, 8'h01, 8'h01);
    chk("post_rst_done", done, 1'b1);
    chk("post_rst_result", result_output, 8'h02);
    chk("post_rst_flags", flags(), 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
